// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner with press/release debounce and
//                multi-key rejection; emits a zero-extended 4-bit key code.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [31:0] number,
    output logic [1:0]  pressed
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [3:0]    row_meta;
    logic [3:0]    rs;
    logic [1:0]    state;
    logic [1:0]    col_idx;
    logic [SW-1:0] slot_cnt;
    logic [DW-1:0] deb_cnt;
    logic [3:0]    cand_row;
    logic [3:0]    cand_code;
    logic [3:0]    key_code;
    logic          held;
    logic          reject;

    logic [2:0]    low_cnt;
    logic [1:0]    row_idx;
    logic          one_low;
    logic [3:0]    scan_code;

    // Column drive follows the registered column index, so reset forces 1110
    // without waiting for a clock edge.
    assign col     = ~(4'b0001 << col_idx);
    assign number  = {28'd0, key_code};
    assign pressed = {reject, held};

    // Count low rows and locate the (last) low row in the synchronized sample.
    always_comb begin
        low_cnt = 3'd0;
        row_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            low_cnt = low_cnt + {2'b00, ~rs[i]};
            if (!rs[i]) begin
                row_idx = 2'(i);
            end
        end
        one_low = (low_cnt == 3'd1);
    end

    // Key map: row index selects the keypad row, column index the column.
    always_comb begin
        scan_code = 4'd0;
        case ({row_idx, col_idx})
            4'b00_00: scan_code = 4'd1;
            4'b00_01: scan_code = 4'd2;
            4'b00_10: scan_code = 4'd3;
            4'b00_11: scan_code = 4'd10;
            4'b01_00: scan_code = 4'd4;
            4'b01_01: scan_code = 4'd5;
            4'b01_10: scan_code = 4'd6;
            4'b01_11: scan_code = 4'd11;
            4'b10_00: scan_code = 4'd7;
            4'b10_01: scan_code = 4'd8;
            4'b10_10: scan_code = 4'd9;
            4'b10_11: scan_code = 4'd12;
            4'b11_00: scan_code = 4'd14;
            4'b11_01: scan_code = 4'd0;
            4'b11_10: scan_code = 4'd15;
            default:  scan_code = 4'd13;
        endcase
    end

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            rs       <= 4'b1111;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // Scan / debounce / hold sequencer; the reject strobe lasts one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            slot_cnt  <= '0;
            deb_cnt   <= '0;
            cand_row  <= 4'b1111;
            cand_code <= 4'd0;
            key_code  <= 4'd0;
            held      <= 1'b0;
            reject    <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (rs == 4'b1111) begin
                            col_idx <= col_idx + 2'd1;
                        end else if (one_low) begin
                            cand_row  <= rs;
                            cand_code <= scan_code;
                            deb_cnt   <= '0;
                            state     <= ST_DEBOUNCE;
                        end else begin
                            reject  <= 1'b1;
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs == cand_row) begin
                        if (deb_cnt == DEB_LAST) begin
                            key_code <= cand_code;
                            held     <= 1'b1;
                            deb_cnt  <= '0;
                            state    <= ST_HELD;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        // Bounce: rescan the same column from a fresh slot.
                        slot_cnt <= '0;
                        state    <= ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (rs == 4'b1111) begin
                        if (deb_cnt == DEB_LAST) begin
                            held     <= 1'b0;
                            deb_cnt  <= '0;
                            slot_cnt <= '0;
                            col_idx  <= col_idx + 2'd1;
                            state    <= ST_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the calculator operand reader: scans a 4x4 matrix keypad, debounces key presses and releases, and emits a 4-bit key code.
- The code is zero-extended to the 32-bit `number` bus, with a `pressed` strobe whose rising edge means one accepted keystroke.
- Codes 0-9 are digits; 14 selects operand 2; 15 selects operand 1.

Parameters:
- SCAN_DIV, 1000, clocks each column is driven before the rows are sampled; minimum 4, to cover synchronizer latency and line settling.
- DEBOUNCE_CYC, 50000, consecutive stable clocks required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- row  input  4  keypad rows, active-low, externally pulled up
- col  output  4  keypad column drive, active-low, one-hot-low while scanning
- number  output  32  code of last accepted key, bits 31:4 always 0
- pressed  output  2  bit0: high from press acceptance until release acceptance; bit1: one-clock multi-key reject pulse

Behaviour:
- Reset values: col=4'b1110, number=0, pressed=2'b00, state=SCAN, col index=0, all counters 0, both synchronizer stages 4'b1111.
- Reset is asynchronous and takes effect immediately, including mid-debounce or HELD; pressed[0] drops in the same reset assertion.
- Input sync: row passes two flops to give rs; all decisions use rs.
- Key map, (row r, column c) -> code:
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 14 (*), 0, 15 (#), 13
- States:
  - SCAN
    - Column c is driven low for SCAN_DIV clocks.
    - On the last clock of the slot, rs is sampled.
    - If rs==4'b1111: c advances mod 4 (3->0 wraps), col updates next clock, slot counter clears.
    - If exactly one rs bit is low: latch candidate row/code, keep col on c, clear debounce counter, go to DEBOUNCE.
    - If two or more rs bits are low: pressed[1]=1 for exactly one clock, treat as no key, advance c.
  - DEBOUNCE
    - Each clock, compare rs with the latched row pattern.
    - Equal: counter increments.
    - Different: return to SCAN at the same column, slot counter cleared, no output change.
    - When the counter reaches DEBOUNCE_CYC-1 with rs still equal: next clock number=code, pressed[0]=1, go to HELD.
  - HELD
    - col stays on c; number and pressed[0] hold.
    - The counter counts consecutive clocks with rs==4'b1111; any low bit clears it.
    - When the counter reaches DEBOUNCE_CYC-1: pressed[0]=0, c advances, go to SCAN.
    - A second key pressed while in HELD is ignored; no rollover.
- Timing:
  - number changes only on press acceptance, in the same clock that pressed[0] rises.
  - number is therefore stable before and through the rising edge of pressed.
- Latency (press to pressed[0] high): at most 4*SCAN_DIV + DEBOUNCE_CYC + 3 clocks from the physical row going low.
- Release latency: DEBOUNCE_CYC + 3 clocks.
- Back-to-back keys: pressed[0] has a minimum low time of one scan slot (SCAN_DIV clocks) between strobes.
- Counters: saturate or clear as stated above, never wrap. Counter widths come from $clog2 of the parameters.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset then idle, rows 4'b1111 for 64 clocks -> col cycles 1110, 1101, 1011, 0111, 1110 every 4 clocks; number=0; pressed=00.
- Key at r1,c2 held 100 clocks then released -> number=6, pressed[0] rises at most 27 clocks after press, falls at most 11 clocks after release, exactly one rising edge.
- Bouncy press on r3,c2 toggling every 3 clocks for 30 clocks, then stable -> no pressed rise during bounce; after stable, number=15, pressed[0]=1.
- Two rows low in column 0 (r0, r2) -> pressed[1] one-clock pulses once per visit to column 0; pressed[0] stays 0; number unchanged.
- Press key 5, then press r3,c0 while 5 is still held -> number stays 5; after both are released and r3,c0 pressed alone, number=14.
- Assert rst mid-DEBOUNCE and again in HELD -> pressed=00, number=0, col=1110 immediately, without waiting for a clock edge.
